// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard control.
package pipe_pkg;

    localparam int NUM_STG = 5;
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_DIV        = 2'd1,
        HZ_REDIR_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/div_cycle_counter.sv
// Down-counter tracking how many EX cycles the divider still needs.
module div_cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Clear beats load beats decrement; no enable means the count is frozen.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int          DIV_CYCLES = 36,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_branch_stall_i,
    input  logic        ex_rmem_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_div_start_i,
    input  logic        if_busy_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        mem_exc_i,
    input  logic        mem_is_eret_i,
    input  logic [31:0] cp0_epc_i,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        div_busy_o,
    output logic        div_done_o
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    hz_state_e   state_q;
    logic [31:0] pc_q;

    logic        exc, bus_wait, load_use, id_stall;
    logic [31:0] exc_target;
    logic        cnt_zero, cnt_load, cnt_dec, div_fin;

    assign exc        = mem_exc_i | mem_is_eret_i;
    assign exc_target = mem_is_eret_i ? cp0_epc_i : EXC_VECTOR;
    assign bus_wait   = mem_req_i & ~mem_ack_i;
    assign load_use   = ex_rmem_i && (ex_waddr_i != 5'd0) &&
                        ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));
    assign id_stall   = load_use | id_branch_stall_i;

    // A divide only starts while EX is free to move; a bus wait keeps it in EX
    // so the start is seen again once the wait clears.
    assign cnt_load = (state_q == HZ_RUN) & ex_div_start_i & ~exc & ~bus_wait;
    assign cnt_dec  = (state_q == HZ_DIV) & ~exc & ~bus_wait;
    assign div_fin  = cnt_dec & cnt_zero;

    div_cycle_counter #(.WIDTH(CNT_W)) u_div_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (exc),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (CNT_INIT),
        .zero_o     (cnt_zero)
    );

    // Hazard state and the last redirect target.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= HZ_RUN;
            pc_q    <= '0;
        end else if (exc) begin
            pc_q    <= exc_target;
            state_q <= if_busy_i ? HZ_REDIR_WAIT : HZ_RUN;
        end else begin
            case (state_q)
                HZ_RUN:        if (cnt_load) state_q <= HZ_DIV;
                HZ_DIV:        if (div_fin) state_q <= HZ_RUN;
                HZ_REDIR_WAIT: if (!if_busy_i) state_q <= HZ_RUN;
                default:       state_q <= HZ_RUN;
            endcase
        end
    end

    // Priority mux: exception > bus wait > divide > ID stall; all outputs are
    // forced low while reset is held so they drop without waiting for a clock.
    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = pc_q;
        div_busy_o    = 1'b0;
        div_done_o    = 1'b0;
        if (!rst_i) begin
            redirect_pc_o = '0;
        end else if (exc) begin
            flush_o[STG_MEM:STG_IF] = 4'b1111;
            redirect_pc_o           = exc_target;
            redirect_o              = ~if_busy_i;
        end else begin
            if (state_q == HZ_REDIR_WAIT) redirect_o = ~if_busy_i;
            div_busy_o = (state_q == HZ_DIV);
            div_done_o = div_fin;
            if (bus_wait) begin
                stall_o         = 5'b01111;
                flush_o[STG_WB] = 1'b1;
            end else if (state_q == HZ_DIV) begin
                stall_o          = cnt_zero ? 5'b00000 : 5'b00111;
                flush_o[STG_MEM] = 1'b1;
            end else if (state_q == HZ_RUN && id_stall) begin
                stall_o         = 5'b00011;
                flush_o[STG_EX] = 1'b1;
            end else if (state_q == HZ_REDIR_WAIT) begin
                stall_o[STG_IF] = 1'b1;
                flush_o[STG_ID] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a 4-cycle divider.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_waddr;
    logic        id_br, ex_rmem, ex_div, if_busy, mem_req, mem_ack, mem_exc, mem_eret;
    logic [31:0] epc;
    logic [4:0]  stall, flush;
    logic        redir, busy, done;
    logic [31:0] redir_pc;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst_n),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_branch_stall_i (id_br),
        .ex_rmem_i         (ex_rmem),
        .ex_waddr_i        (ex_waddr),
        .ex_div_start_i    (ex_div),
        .if_busy_i         (if_busy),
        .mem_req_i         (mem_req),
        .mem_ack_i         (mem_ack),
        .mem_exc_i         (mem_exc),
        .mem_is_eret_i     (mem_eret),
        .cp0_epc_i         (epc),
        .stall_o           (stall),
        .flush_o           (flush),
        .redirect_o        (redir),
        .redirect_pc_o     (redir_pc),
        .div_busy_o        (busy),
        .div_done_o        (done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_waddr = 0; id_br = 0; ex_rmem = 0; ex_div = 0;
        if_busy = 0; mem_req = 0; mem_ack = 0; mem_exc = 0; mem_eret = 0; epc = 0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled 2 units after inputs change, well before the next edge.
    task automatic chk_so(input string tag, input logic [4:0] s, input logic [4:0] f);
        #2;
        chk({tag, ".stall"}, stall, s);
        chk({tag, ".flush"}, flush, f);
    endtask

    initial begin
        int done_cyc;
        int done_cnt;
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst.stall", stall, 0);
        chk("rst.flush", flush, 0);
        chk("rst.redir", redir, 0);
        chk("rst.pc", redir_pc, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        #10 rst_n = 1'b1;
        nxt();

        // load-use on rs
        ex_rmem = 1; ex_waddr = 5; id_rs = 5;
        chk_so("lu_rs", 5'b00011, 5'b00100);
        nxt(); idle();
        chk_so("lu_clr", 5'b00000, 5'b00000);
        // r0 destination never stalls
        nxt(); ex_rmem = 1; ex_waddr = 0; id_rs = 0;
        chk_so("lu_r0", 5'b00000, 5'b00000);
        // load-use on rt
        nxt(); idle(); ex_rmem = 1; ex_waddr = 7; id_rt = 7; id_rs = 3;
        chk_so("lu_rt", 5'b00011, 5'b00100);
        // non-load writer does not stall
        nxt(); ex_rmem = 0;
        chk_so("nolu", 5'b00000, 5'b00000);
        // branch operand stall
        nxt(); idle(); id_br = 1;
        chk_so("br", 5'b00011, 5'b00100);

        // divide: start cycle is plain RUN, then 4 DIV cycles
        nxt(); idle(); ex_div = 1;
        chk_so("div0", 5'b00000, 5'b00000);
        chk("div0.busy", busy, 0);
        for (int c = 1; c <= 4; c++) begin
            nxt(); idle();
            chk_so($sformatf("div%0d", c), (c == 4) ? 5'b00000 : 5'b00111, 5'b01000);
            chk($sformatf("div%0d.busy", c), busy, 1);
            chk($sformatf("div%0d.done", c), done, (c == 4) ? 1 : 0);
        end
        nxt();
        chk_so("div5", 5'b00000, 5'b00000);
        chk("div5.busy", busy, 0);

        // bus wait for 3 cycles in the middle of a divide pushes done out by 3
        nxt(); idle(); ex_div = 1;
        #2;
        done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            nxt(); idle();
            if (c >= 2 && c <= 4) begin
                mem_req = 1;
                chk_so($sformatf("bw%0d", c), 5'b01111, 5'b10000);
                chk($sformatf("bw%0d.busy", c), busy, 1);
            end else begin
                #2;
            end
            if (done === 1'b1) done_cyc = c;
        end
        chk("bw.done_cycle", done_cyc, 7);

        // exception mid-divide with IF idle: immediate redirect, divide abandoned
        nxt(); idle(); ex_div = 1;
        nxt(); idle();
        nxt(); mem_exc = 1;
        chk_so("exc", 5'b00000, 5'b01111);
        chk("exc.redir", redir, 1);
        chk("exc.pc", redir_pc, 32'hBFC0_0380);
        chk("exc.busy", busy, 0);
        chk("exc.done", done, 0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            nxt(); idle();
            #2;
            done_cnt += int'(done) + int'(busy);
        end
        chk("exc.no_done", done_cnt, 0);
        chk("exc.pc_hold", redir_pc, 32'hBFC0_0380);
        chk("exc.redir_low", redir, 0);

        // ERET while IF is busy: latch EPC, hold IF, redirect when fetch finishes
        nxt(); mem_eret = 1; epc = 32'h8000_1234; if_busy = 1;
        chk_so("eret", 5'b00000, 5'b01111);
        chk("eret.redir", redir, 0);
        for (int c = 1; c <= 2; c++) begin
            nxt(); idle(); if_busy = 1;
            chk_so($sformatf("rw%0d", c), 5'b00001, 5'b00010);
            chk($sformatf("rw%0d.redir", c), redir, 0);
        end
        nxt(); idle();
        chk_so("rw_go", 5'b00001, 5'b00010);
        chk("rw_go.redir", redir, 1);
        chk("rw_go.pc", redir_pc, 32'h8000_1234);
        nxt();
        chk_so("rw_done", 5'b00000, 5'b00000);
        chk("rw_done.redir", redir, 0);
        chk("rw_done.pc", redir_pc, 32'h8000_1234);

        // asynchronous reset mid-divide
        nxt(); ex_div = 1;
        nxt(); idle();
        nxt();
        #2;
        chk("rd.busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rd.stall", stall, 0);
        chk("rd.flush", flush, 0);
        chk("rd.busy", busy, 0);
        chk("rd.pc", redir_pc, 0);
        nxt();
        #3 rst_n = 1'b1;
        nxt(); ex_div = 1;
        #2;
        chk("rd.run_busy", busy, 0);
        nxt(); idle();
        #2;
        chk("rd.div_again", busy, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
